// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the pipelined Avalon-MM on-chip RAM.
package onchip_ram_pkg;
  localparam int MAX_READ_LATENCY = 2;

  typedef enum logic {ST_CLEAR, ST_READY} ram_state_e;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/onchip_ram_bank.sv
// DEPTH x DATA_W inferred RAM: per-byte write enables, one registered read port.
module onchip_ram_bank
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [be_w(DATA_W)-1:0]   we,
  input  logic [AW-1:0]             waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [AW-1:0]             raddr,
  output logic [DATA_W-1:0]         rdata
);
  localparam int NB = be_w(DATA_W);

  logic [NB-1:0][7:0] mem [DEPTH];
  logic [NB-1:0][7:0] wbytes;

  assign wbytes = wdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (we[b]) mem[waddr][b] <= wbytes[b];
  end

  // Output register is reset so readdata comes up as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end
endmodule

// File: rtl/onchip_ram_avalon_pipelined.sv
// Avalon-MM single-port RAM slave: zero-fill after reset, 1/2-cycle read pipeline.
module onchip_ram_avalon_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 2**ADDR_W,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_W-1:0]       address,
  input  logic [be_w(DATA_W)-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_W-1:0]       writedata,
  output logic [DATA_W-1:0]       readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_busy
);
  localparam int NB    = be_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  ram_state_e              state_q, state_d;
  logic [IDX_W-1:0]        clr_q, clr_d;
  logic                    in_range, acc, acc_rd, acc_wr;
  logic [NB-1:0]           bank_we;
  logic [IDX_W-1:0]        bank_waddr;
  logic [DATA_W-1:0]       bank_wdata, bank_q, stage1;
  logic                    oob_q;
  logic [READ_LATENCY:1]   vld_q;
  logic [READ_LATENCY:0]   vld_pipe;

  assign waitrequest = (state_q == ST_CLEAR) | ~clken;
  assign init_busy   = (state_q == ST_CLEAR);
  assign acc         = chipselect & (read | write) & ~waitrequest;
  assign acc_wr      = acc & write;
  // A simultaneous read+write performs only the write.
  assign acc_rd      = acc & read & ~write;
  assign in_range    = {1'b0, address} < DEPTH_L;
  assign vld_pipe    = {vld_q, acc_rd};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    bank_we    = '0;
    bank_waddr = address[IDX_W-1:0];
    bank_wdata = writedata;
    case (state_q)
      ST_CLEAR: if (clken) begin
        bank_we    = '1;
        bank_waddr = clr_q;
        bank_wdata = '0;
        clr_d      = clr_q + 1'b1;
        if (clr_q == LAST) state_d = ST_READY;
      end
      ST_READY: if (acc_wr && in_range) bank_we = byteenable;
      default:  state_d = ST_READY;
    endcase
  end

  onchip_ram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IDX_W)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (bank_we),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .re      (acc_rd & in_range),
    .raddr   (address[IDX_W-1:0]),
    .rdata   (bank_q)
  );

  // Out-of-range reads skip the bank and are masked to zero at stage 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      oob_q <= 1'b0;
    end else if (clken) begin
      vld_q <= vld_pipe[READ_LATENCY-1:0];
      if (acc_rd) oob_q <= ~in_range;
    end
  end

  assign stage1        = oob_q ? '0 : bank_q;
  assign readdatavalid = vld_pipe[READ_LATENCY] & clken;

  if (READ_LATENCY >= MAX_READ_LATENCY) begin : g_lat2
    logic [DATA_W-1:0] rd2_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   rd2_q <= '0;
      else if (clken && vld_pipe[1])  rd2_q <= stage1;
    end
    assign readdata = rd2_q;
  end else begin : g_lat1
    assign readdata = stage1;
  end
endmodule

// File: tb/tb_onchip_ram_avalon_pipelined.sv
// Bench: behavioural RAM/queue model checked every cycle, plus directed literal checks.
module tb_onchip_ram_avalon_pipelined;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int RL     = 2;

  logic              clk = 1'b0, reset_n = 1'b0, clken = 1'b1;
  logic              chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [3:0]        byteenable = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              readdatavalid, waitrequest, init_busy;

  int   checks = 0, passes = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  onchip_ram_avalon_pipelined #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest), .init_busy(init_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: word array, remaining zero-fill count, queue of pending read results.
  typedef struct { logic [31:0] d; int cnt; } ent_t;
  ent_t        pq[$];
  logic [31:0] mem_m [DEPTH];
  int          clr_left = DEPTH;
  logic [31:0] last_rd = '0;

  initial for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pq.delete();
      clr_left = DEPTH;
      last_rd  = '0;
    end else if (clken) begin
      if (pq.size() > 0 && pq[0].cnt == 0) begin
        last_rd = pq[0].d;
        void'(pq.pop_front());
      end
      foreach (pq[i]) pq[i].cnt = pq[i].cnt - 1;
      if (clr_left > 0) begin
        mem_m[DEPTH - clr_left] = '0;
        clr_left--;
      end else if (chipselect && (read || write)) begin
        if (write) begin
          if (address < DEPTH)
            for (int b = 0; b < 4; b++)
              if (byteenable[b]) mem_m[address[3:0]][8*b +: 8] = writedata[8*b +: 8];
        end else begin
          pq.push_back('{(address < DEPTH) ? mem_m[address[3:0]] : 32'h0, RL - 1});
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic e_rdv;
    if (mon_on) begin
      e_rdv = 1'b0;
      if (reset_n && clken && pq.size() > 0) e_rdv = (pq[0].cnt == 0);
      chk("waitrequest", waitrequest, (!reset_n || clr_left > 0 || !clken));
      chk("init_busy", init_busy, (clr_left > 0));
      chk("readdatavalid", readdatavalid, e_rdv);
      if (e_rdv)      chk("readdata", readdata, pq[0].d);
      else if (clken) chk("readdata_hold", readdata, last_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = ADDR_W'(a); writedata = d; byteenable = be;
    step();
    idle();
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [31:0] exp);
    int n;
    n = 0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = ADDR_W'(a);
    step();
    idle();
    while (!readdatavalid && n < 10) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, RL - 1);
    chk(nm, readdata, exp);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    step();
    mon_on = 1'b1;
    step();
    step();

    reset_n = 1'b1;
    n = 0;
    while (waitrequest && n < 100) begin n++; step(); end
    chk("clear_cycles", n, 16);

    rd_chk("read_after_clear", 5, 32'h0000_0000);

    wr(3, 32'hDEAD_BEEF, 4'b1111);
    wr(3, 32'h1122_3344, 4'b0101);
    rd_chk("byte_merge", 3, 32'hDE22_BE44);

    for (int i = 0; i < 8; i++) wr(i, 32'h1000_0000 + i * 32'h111, 4'hF);
    for (int i = 0; i < RL + 8; i++) begin
      if (i < 8) begin
        chipselect = 1'b1; read = 1'b1; address = ADDR_W'(i);
      end else idle();
      if (i >= RL) begin
        chk("b2b_valid", readdatavalid, 1'b1);
        chk("b2b_data", readdata, 32'h1000_0000 + (i - RL) * 32'h111);
      end else chk("b2b_early", readdatavalid, 1'b0);
      step();
    end
    idle();

    wr(9, 32'hA5A5_A5A5, 4'hF);
    rd_chk("read_after_write", 9, 32'hA5A5_A5A5);

    wr(20, 32'hFFFF_FFFF, 4'hF);
    rd_chk("oob_no_alias", 4, 32'h1000_0444);
    rd_chk("oob_read_zero", 20, 32'h0);

    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 6;
    writedata = 32'hCAFE_F00D; byteenable = 4'hF;
    step();
    idle();
    n = 0;
    repeat (4) begin if (readdatavalid) n++; step(); end
    chk("rw_read_dropped", n, 0);
    rd_chk("rw_write_done", 6, 32'hCAFE_F00D);

    chipselect = 1'b1; read = 1'b1; address = 2;
    step();
    idle();
    step();
    clken = 1'b0;
    n = 0;
    repeat (3) begin #1; if (readdatavalid) n++; step(); end
    chk("stall_suppressed", n, 0);
    clken = 1'b1;
    #1;
    chk("stall_release_valid", readdatavalid, 1'b1);
    chk("stall_release_data", readdata, 32'h1000_0222);
    step();

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (7) step();
    reset_n = 1'b0;
    chipselect = 1'b1; read = 1'b1; address = 9;
    #1;
    chk("wait_in_reset", waitrequest, 1'b1);
    step();
    reset_n = 1'b1;
    n = 0;
    while (waitrequest && n < 100) begin n++; step(); end
    chk("clear_restart_cycles", n, 16);
    step();
    idle();
    n = 0;
    while (!readdatavalid && n < 10) begin step(); n++; end
    chk("post_clear_valid", readdatavalid, 1'b1);
    chk("post_clear_data", readdata, 32'h0);
    step();

    repeat (600) begin
      clken      = ($urandom_range(0, 9) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read       = $urandom_range(0, 1) != 0;
      write      = $urandom_range(0, 2) == 0;
      address    = ADDR_W'($urandom_range(0, 19));
      byteenable = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      step();
    end
    idle();
    clken = 1'b1;
    repeat (6) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/onchip_ram_avalon_pipelined.md
# onchip_ram_avalon_pipelined

Parametrised Avalon-MM single-port on-chip RAM slave for the Proyecto3 system interconnect. It is the successor to the fixed 16K×32 unregistered on-chip memory. It adds:
- configurable width and depth;
- a selectable 1- or 2-cycle pipelined read with `readdatavalid`;
- `waitrequest` back-pressure;
- an optional hardware zero-fill engine that clears the array after reset.

## Interface
- `DATA_W`, 32: data width in bits; must be a multiple of 8, range 8..128.
- `ADDR_W`, 14: word-address width.
- `DEPTH`, 2**`ADDR_W`: number of words; must be ≤ 2**`ADDR_W`.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- `CLEAR_ON_RESET`, 1: when 1, zero-fill all words after every reset.
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  clock enable; 0 stalls the block.
- `address`  in  `ADDR_W`  word address.
- `byteenable`  in  `DATA_W`/8  per-byte write mask.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  `DATA_W`  write data.
- `readdata`  out  `DATA_W`  read data; valid only while `readdatavalid`=1.
- `readdatavalid`  out  1  one-cycle pulse per accepted read.
- `waitrequest`  out  1  1 = request not accepted this cycle.
- `init_busy`  out  1  zero-fill in progress.

## Operation
- Reset (`reset_n`=0) forces these outputs:
  - `readdata`=0, `readdatavalid`=0, read pipeline flushed;
  - with `CLEAR_ON_RESET`=1: FSM enters CLEAR with `clr_addr`=0, `waitrequest`=1, `init_busy`=1;
  - with `CLEAR_ON_RESET`=0: FSM enters READY, `waitrequest`=0, `init_busy`=0.
- FSM states:
  - CLEAR: each cycle with `clken`=1, write 0 to all bytes of `clr_addr`, then increment it. On `clr_addr`=`DEPTH`-1, the final word is written and the FSM moves to READY next cycle.
  - READY: serve bus requests; stays here until reset.
- Acceptance: `acc` = `chipselect` & (`read` | `write`) & ~`waitrequest`.
  - `waitrequest` = (state==CLEAR) | ~`clken`.
- Write: byte i of word `address` is updated iff `byteenable`[i]=1; other bytes are unchanged. A `byteenable` of 0 is accepted as a no-op.
- Read: on acceptance, the array is read and data enters a `READ_LATENCY`-deep valid/data pipeline.
- `read` and `write` both asserted: the write is performed and the read is dropped (no `readdatavalid`).
- Read-during-write to the same address on consecutive cycles: the later read returns the newly written data, with no stale hazard.
- `address` ≥ `DEPTH`: writes are ignored; reads return 0 with a normal `readdatavalid`.
- `clken`=0:
  - the pipeline is frozen and its contents are preserved;
  - `readdatavalid` is forced to 0;
  - the held result is emitted once `clken` returns to 1;
  - the CLEAR counter does not advance.
- Reset asserted mid-CLEAR or with reads in flight: the pipeline is flushed and CLEAR restarts from address 0. Array contents are not otherwise defined by reset.

## Timing
- Read accepted in cycle N → `readdatavalid`=1 with data in cycle N+`READ_LATENCY`, assuming `clken`=1 throughout.
- Full throughput: one accepted read or write per cycle in READY.
- A write in cycle N is visible to a read accepted in cycle N+1.
- CLEAR lasts exactly `DEPTH` enabled cycles. The first bus access can be accepted in cycle `DEPTH`+1 after reset release.
- `readdata` holds its last value while `readdatavalid`=0.

## Structure
- Package `onchip_ram_pkg` contains:
  - state enum `{ST_CLEAR, ST_READY}`;
  - `function automatic be_w(DATA_W)` returning `DATA_W`/8;
  - constant `MAX_READ_LATENCY`=2.
- Sub-module `onchip_ram_bank`: an inferred `DEPTH`×`DATA_W` array with a per-byte write enable and one synchronous read port. The top level holds the FSM, clear counter, arbitration and read pipeline.

## Test plan
- Reset release with `DEPTH`=16, `CLEAR_ON_RESET`=1 → `waitrequest`=1 for 16 cycles, then 0. A read of address 5 returns 0x00000000.
- Write 0xDEADBEEF to address 3 with `byteenable`=4'b1111, then write 0x11223344 with `byteenable`=4'b0101 → a read of address 3 returns 0xDE22BE44.
- Back-to-back reads of addresses 0..7 with `READ_LATENCY`=2 → eight consecutive `readdatavalid` pulses starting 2 cycles after the first acceptance, with data in order.
- Write 0xA5A5A5A5 to address 9, then read address 9 on the next cycle → returns 0xA5A5A5A5.
- Read accepted, then `clken`=0 for 3 cycles → `readdatavalid` is suppressed and the data emerges unchanged on the first cycle with `clken`=1.
- Assert `reset_n`=0 at `clr_addr`=7, then release → CLEAR restarts and lasts the full 16 cycles. A read issued in the meantime sees `waitrequest`=1.
